ioctl_sdram_loader: RTL and testbench

//  Sits between data_io (ioctl byte stream) and the sdram byte port, replacing the inline download/CPU mux.

---
 rtl/ioctl_sdram_loader_if.sv | 35 +++
 rtl/ioctl_sdram_loader.sv | 126 ++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_sdram_loader_if.sv
// Bus bundle between data_io/core and the sdram byte port, seen from the loader.
// Pure wiring, no latency; ram_ready is the only flow control back to the source.
// slave = loader side, master = environment (data_io, core, sdram).
interface ioctl_sdram_loader_if #(
  parameter int ADDR_W = 23
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_we_n;
  logic              cpu_oe_n;
  logic              ram_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              ram_rd;
  logic              busy;
  logic              done;
  logic              overflow;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_addr, cpu_din, cpu_we_n, cpu_oe_n, ram_ready,
    output ram_addr, ram_din, ram_we, ram_rd, busy, done, overflow
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_addr, cpu_din, cpu_we_n, cpu_oe_n, ram_ready,
    input  ram_addr, ram_din, ram_we, ram_rd, busy, done, overflow
  );
endinterface

// File: rtl/ioctl_sdram_loader.sv
// Buffers ioctl download bytes in a FIFO and writes them to sdram; CPU passthrough when idle.
// Latency: push to ram_we >= 2 cycles; at most one write per MIN_WAIT+1 cycles.
// Backpressure: paced by ram_ready; ioctl has none, so a push into a full FIFO is dropped and flagged.
module ioctl_sdram_loader #(
  parameter int                ADDR_W     = 23,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                MIN_WAIT   = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  ioctl_sdram_loader_if.slave  bus
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(MIN_WAIT + 1) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dat;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              empty, full;
  logic              push_req, push, pop, drop;
  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic              wait_done;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic              we_q;
  logic              busy_q, busy_nxt, done_q;
  logic              dl_q, overflow_q;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign head      = mem[rd_ptr[IW-1:0]];
  assign push_req  = bus.ioctl_download && bus.ioctl_wr;
  // A simultaneous pop frees the slot, so full only blocks when nothing leaves.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign wait_done = (int'(wait_cnt) + 1 >= MIN_WAIT);
  assign busy_nxt  = bus.ioctl_download || !empty || (state != ST_IDLE);

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[IW-1:0]] <= '{addr: bus.ioctl_addr + BASE_ADDR, dat: bus.ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && bus.ram_ready) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_done && bus.ram_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // wait_cnt counts WAIT cycles already spent; the strobe cycle is the first of them.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr_q   <= head.addr;
        din_q    <= head.dat;
        wait_cnt <= '0;
      end else if (state == ST_WAIT && !wait_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dl_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= busy_q && !busy_nxt;
      dl_q   <= bus.ioctl_download;
      if (bus.ioctl_download && !dl_q) overflow_q <= 1'b0;
      if (drop)                        overflow_q <= 1'b1;
    end
  end

  assign bus.ram_addr = busy_q ? addr_q : bus.cpu_addr;
  assign bus.ram_din  = busy_q ? din_q  : bus.cpu_din;
  assign bus.ram_we   = busy_q ? we_q   : ~bus.cpu_we_n;
  assign bus.ram_rd   = busy_q ? 1'b0   : ~bus.cpu_oe_n;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench: stimulus queues expected {addr,data} writes, a negedge monitor pops on every loader write.
module tb_ioctl_sdram_loader;
  localparam int MIN_WAIT = 2;

  logic clk;
  logic reset_n;

  ioctl_sdram_loader_if #(.ADDR_W(23)) b0 ();
  ioctl_sdram_loader_if #(.ADDR_W(23)) b1 ();

  ioctl_sdram_loader #(.ADDR_W(23), .FIFO_DEPTH(8), .BASE_ADDR(23'h0), .MIN_WAIT(MIN_WAIT)) dut0 (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (b0)
  );

  ioctl_sdram_loader #(.ADDR_W(23), .FIFO_DEPTH(8), .BASE_ADDR(23'h7FFFFE), .MIN_WAIT(MIN_WAIT)) dut1 (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  typedef struct {
    logic [22:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   wr0 = 0, wr1 = 0, done0 = 0, done1 = 0;
  int   last0 = -1, last1 = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && b0.busy && b0.ram_we) begin
      wr0++;
      if (q0.size() == 0) check("wr0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        check("wr0_addr", b0.ram_addr, e.a);
        check("wr0_data", b0.ram_din, e.d);
      end
      if (last0 >= 0) check("wr0_spacing", (cyc - last0) >= MIN_WAIT + 1, 1);
      last0 = cyc;
    end
    if (reset_n && b1.busy && b1.ram_we) begin
      wr1++;
      if (q1.size() == 0) check("wr1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        check("wr1_addr", b1.ram_addr, e.a);
        check("wr1_data", b1.ram_din, e.d);
      end
      if (last1 >= 0) check("wr1_spacing", (cyc - last1) >= MIN_WAIT + 1, 1);
      last1 = cyc;
    end
    if (b0.done) begin
      done0++;
      check("done0_busy_low", b0.busy, 0);
    end
    if (b1.done) done1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until the scoreboard is drained and the loader has released the RAM.
  task automatic wait_idle(input int sel, input string name, input int limit);
    int n = 0;
    if (sel == 0) while ((q0.size() != 0 || b0.busy) && n < limit) begin tick(); n++; end
    else          while ((q1.size() != 0 || b1.busy) && n < limit) begin tick(); n++; end
    check(name, n < limit, 1);
    q0.delete();
    q1.delete();
  endtask

  task automatic push0(input logic [22:0] a, input logic [7:0] d);
    b0.ioctl_addr = a;
    b0.ioctl_dout = d;
    b0.ioctl_wr   = 1'b1;
    q0.push_back('{a: a, d: d});
    tick();
    b0.ioctl_wr = 1'b0;
    tick();
  endtask

  initial begin
    int          w, dn;
    logic [22:0] exp6 [4];
    exp6 = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};

    reset_n           = 1'b0;
    b0.ioctl_download = 1'b0; b0.ioctl_wr = 1'b0; b0.ioctl_addr = '0; b0.ioctl_dout = '0;
    b0.cpu_addr = 23'h1234; b0.cpu_din = 8'h5A; b0.cpu_we_n = 1'b0; b0.cpu_oe_n = 1'b0;
    b0.ram_ready = 1'b1;
    b1.ioctl_download = 1'b0; b1.ioctl_wr = 1'b0; b1.ioctl_addr = '0; b1.ioctl_dout = '0;
    b1.cpu_addr = '0; b1.cpu_din = '0; b1.cpu_we_n = 1'b1; b1.cpu_oe_n = 1'b1;
    b1.ram_ready = 1'b1;

    // 1: reset state and CPU passthrough
    #12;
    check("rst_ram_we", b0.ram_we, 1);
    check("rst_ram_addr", b0.ram_addr, 23'h1234);
    check("rst_ram_din", b0.ram_din, 8'h5A);
    check("rst_ram_rd", b0.ram_rd, 1);
    check("rst_busy", b0.busy, 0);
    check("rst_overflow", b0.overflow, 0);
    check("rst_done", b0.done, 0);
    b0.cpu_we_n = 1'b1;
    b0.cpu_oe_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("pass_ram_we", b0.ram_we, 0);
    check("pass_ram_rd", b0.ram_rd, 0);

    // 2: 16 paced pushes, data = addr ^ A5
    w = wr0; dn = done0;
    b0.ioctl_download = 1'b1;
    tick();
    check("t2_busy_on", b0.busy, 1);
    for (int i = 0; i < 16; i++) push0(23'(i), 8'(i) ^ 8'hA5);
    b0.ioctl_download = 1'b0;
    wait_idle(0, "t2_drain", 300);
    repeat (3) tick();
    check("t2_writes", wr0 - w, 16);
    check("t2_done", done0 - dn, 1);
    check("t2_overflow", b0.overflow, 0);

    // 3: nine back-to-back pushes into a stalled FIFO
    w = wr0; dn = done0;
    b0.ram_ready = 1'b0;
    b0.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      b0.ioctl_addr = 23'h100 + 23'(i);
      b0.ioctl_dout = 8'h30 + 8'(i);
      b0.ioctl_wr   = 1'b1;
      if (i < 8) q0.push_back('{a: 23'h100 + 23'(i), d: 8'h30 + 8'(i)});
      tick();
    end
    b0.ioctl_wr = 1'b0;
    tick();
    check("t3_overflow", b0.overflow, 1);
    check("t3_stalled", wr0 - w, 0);
    b0.ram_ready = 1'b1;
    b0.ioctl_download = 1'b0;
    wait_idle(0, "t3_drain", 300);
    repeat (3) tick();
    check("t3_writes", wr0 - w, 8);
    check("t3_overflow_sticky", b0.overflow, 1);
    check("t3_done", done0 - dn, 1);

    // 4: push into a full FIFO in the same cycle as a pop
    w = wr0;
    b0.ram_ready = 1'b0;
    b0.ioctl_download = 1'b1;
    tick();
    check("t4_overflow_cleared", b0.overflow, 0);
    for (int i = 0; i < 8; i++) begin
      b0.ioctl_addr = 23'h200 + 23'(i);
      b0.ioctl_dout = 8'h40 + 8'(i);
      b0.ioctl_wr   = 1'b1;
      q0.push_back('{a: 23'h200 + 23'(i), d: 8'h40 + 8'(i)});
      tick();
    end
    b0.ioctl_addr = 23'h208;
    b0.ioctl_dout = 8'h48;
    b0.ram_ready  = 1'b1;
    q0.push_back('{a: 23'h208, d: 8'h48});
    tick();
    b0.ioctl_wr = 1'b0;
    tick();
    check("t4_overflow", b0.overflow, 0);
    b0.ioctl_download = 1'b0;
    wait_idle(0, "t4_drain", 300);
    check("t4_writes", wr0 - w, 9);

    // 5: reset in the middle of a drain
    w = wr0;
    b0.ram_ready = 1'b0;
    b0.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      b0.ioctl_addr = 23'h300 + 23'(i);
      b0.ioctl_dout = 8'h60 + 8'(i);
      b0.ioctl_wr   = 1'b1;
      q0.push_back('{a: 23'h300 + 23'(i), d: 8'h60 + 8'(i)});
      tick();
    end
    b0.ioctl_wr = 1'b0;
    b0.ioctl_download = 1'b0;
    b0.ram_ready = 1'b1;
    for (int n = 0; n < 50 && wr0 == w; n++) tick();
    check("t5_first_write", wr0 - w, 1);
    reset_n = 1'b0;
    #1;
    check("t5_busy_rst", b0.busy, 0);
    check("t5_ram_we_rst", b0.ram_we, 0);
    q0.delete();
    w = wr0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("t5_no_writes", wr0 - w, 0);
    check("t5_busy_after", b0.busy, 0);

    // 6: base offset wraps modulo 2^23
    w = wr1;
    b1.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      b1.ioctl_addr = 23'(i);
      b1.ioctl_dout = 8'h10 + 8'(i);
      b1.ioctl_wr   = 1'b1;
      q1.push_back('{a: exp6[i], d: 8'h10 + 8'(i)});
      tick();
      b1.ioctl_wr = 1'b0;
      tick();
    end
    b1.ioctl_download = 1'b0;
    wait_idle(1, "t6_drain", 200);
    repeat (3) tick();
    check("t6_writes", wr1 - w, 4);
    check("t6_done", done1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
